// File: rtl/fetch_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_line_buffer
// Purpose  : Single-line instruction fetch buffer. It fetches 64-byte lines
//            and hands out 32-bit words with a ready/valid handshake and
//            redirect support. Optional macro FETCH_SAME_LINE_HIT_EN lets a
//            redirect that lands in the buffered line skip the refetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_line_buffer #(
    parameter logic [63:0] START_PC = 64'h0
) (
    input  logic           clk,
    input  logic           reset,
    output logic           line_reqcyc,
    output logic [63:0]    line_addr,
    input  logic           line_respcyc,
    input  logic [0:511]   line_data,
    output logic           inst_valid,
    input  logic           inst_ready,
    output logic [31:0]    inst_data,
    output logic [63:0]    inst_pc,
    input  logic           redirect,
    input  logic [63:0]    redirect_pc
);

    localparam logic [63:0] C_START_PC = START_PC & ~64'h3;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_SERVE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    logic [63:0]    r_pc;
    logic [63:0]    r_req_addr;
    logic [63:0]    r_tag;
    logic [0:511]   r_line;
`ifdef FETCH_SAME_LINE_HIT_EN
    logic           r_tag_valid;
`endif

    logic [63:0]    w_redirect_pc;
    logic [63:0]    w_pc_line;
    logic [8:0]     w_bit_base;
    logic           w_same_line_hit;

    assign w_redirect_pc = redirect_pc & ~64'h3;
    assign w_pc_line     = {r_pc[63:6], 6'b0};
    assign w_bit_base    = {r_pc[5:2], 5'b0};

`ifdef FETCH_SAME_LINE_HIT_EN
    assign w_same_line_hit = r_tag_valid && (redirect_pc[63:6] == r_tag[63:6]);
`else
    assign w_same_line_hit = 1'b0;
`endif

    // Reset gates the request outputs so nothing leaks while state sits in REQ.
    assign line_reqcyc = (r_state == S_REQ) && !reset;
    assign line_addr   = reset                 ? 64'h0     :
                         (r_state == S_REQ)    ? w_pc_line :
                         (r_state == S_SERVE)  ? r_tag     : r_req_addr;
    assign inst_valid  = (r_state == S_SERVE);
    assign inst_pc     = inst_valid ? r_pc : 64'h0;
    assign inst_data   = inst_valid ? r_line[w_bit_base +: 32] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= C_START_PC;
            r_req_addr  <= 64'h0;
            r_tag       <= 64'h0;
            r_line      <= '0;
`ifdef FETCH_SAME_LINE_HIT_EN
            r_tag_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    r_req_addr <= w_pc_line;
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= line_respcyc ? S_REQ : S_DRAIN;
                    end else if (line_respcyc) begin
                        r_line      <= line_data;
                        r_tag       <= r_req_addr;
`ifdef FETCH_SAME_LINE_HIT_EN
                        r_tag_valid <= 1'b1;
`endif
                        r_state     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                        if (!w_same_line_hit) begin
                            r_state <= S_REQ;
                        end
                    end else if (inst_ready) begin
                        r_pc <= r_pc + 64'd4;
                        if (r_pc[5:2] == 4'hF) begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    // The in-flight response is swallowed; buffer and tag keep their contents.
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (line_respcyc) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
`default_nettype none
// Directed testbench for fetch_line_buffer (START_PC = 0x1000).
module tb_fetch_line_buffer;

    logic           clk = 1'b0;
    logic           reset;
    logic           line_reqcyc;
    logic [63:0]    line_addr;
    logic           line_respcyc;
    logic [0:511]   line_data;
    logic           inst_valid;
    logic           inst_ready;
    logic [31:0]    inst_data;
    logic [63:0]    inst_pc;
    logic           redirect;
    logic [63:0]    redirect_pc;

    int checks   = 0;
    int failures = 0;

    fetch_line_buffer #(.START_PC(64'h1000)) dut (
        .clk          (clk),
        .reset        (reset),
        .line_reqcyc  (line_reqcyc),
        .line_addr    (line_addr),
        .line_respcyc (line_respcyc),
        .line_data    (line_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Word at byte address A reads as A[31:0] + 0x5000_0000.
    function automatic logic [0:511] make_line(input logic [63:0] a);
        logic [0:511] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = a[31:0] + 32'(4*i) + 32'h5000_0000;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [63:0] a);
        line_respcyc = 1'b1;
        line_data    = make_line(a);
        tick();
        line_respcyc = 1'b0;
        line_data    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; line_respcyc = 1'b0; line_data = '0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 64'h0;
        repeat (3) tick();
        if (line_reqcyc !== 1'b0) begin $display("FAIL rst_reqcyc got=%0b exp=0", line_reqcyc); failures++; end checks++;
        if (line_addr !== 64'h0) begin $display("FAIL rst_addr got=%h exp=0", line_addr); failures++; end checks++;
        if (inst_valid !== 1'b0) begin $display("FAIL rst_valid got=%0b exp=0", inst_valid); failures++; end checks++;
        if (inst_pc !== 64'h0 || inst_data !== 32'h0) begin $display("FAIL rst_inst got=%h/%h exp=0/0", inst_pc, inst_data); failures++; end checks++;
        reset = 1'b0;
        #1;
        if (line_reqcyc !== 1'b1) begin $display("FAIL rel_reqcyc got=%0b exp=1", line_reqcyc); failures++; end checks++;
        if (line_addr !== 64'h1000) begin $display("FAIL rel_addr got=%h exp=1000", line_addr); failures++; end checks++;
    endtask

    task automatic test_first_fetch();
        tick();
        if (line_reqcyc !== 1'b0) begin $display("FAIL wait_reqcyc got=%0b exp=0", line_reqcyc); failures++; end checks++;
        if (line_addr !== 64'h1000) begin $display("FAIL wait_addr got=%h exp=1000", line_addr); failures++; end checks++;
        if (inst_valid !== 1'b0) begin $display("FAIL wait_valid got=%0b exp=0", inst_valid); failures++; end checks++;
        tick();
        tick();
        respond(64'h1000);
        if (inst_valid !== 1'b1) begin $display("FAIL first_valid got=%0b exp=1", inst_valid); failures++; end checks++;
        if (inst_pc !== 64'h1000) begin $display("FAIL first_pc got=%h exp=1000", inst_pc); failures++; end checks++;
        if (inst_data !== 32'h5000_1000) begin $display("FAIL first_data got=%h exp=50001000", inst_data); failures++; end checks++;
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        inst_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_pc = 64'h1000 + 64'(4*i);
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
                $display("FAIL stream_pc[%0d] got=%0b/%h exp=1/%h", i, inst_valid, inst_pc, exp_pc); failures++;
            end checks++;
            if (inst_data !== exp_pc[31:0] + 32'h5000_0000) begin
                $display("FAIL stream_data[%0d] got=%h exp=%h", i, inst_data, exp_pc[31:0] + 32'h5000_0000); failures++;
            end checks++;
            tick();
        end
        inst_ready = 1'b0;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h1040) begin $display("FAIL stream_next_req got=%0b/%h exp=1/1040", line_reqcyc, line_addr); failures++; end checks++;
        if (inst_valid !== 1'b0 || inst_pc !== 64'h0) begin $display("FAIL stream_req_inst got=%0b/%h exp=0/0", inst_valid, inst_pc); failures++; end checks++;
        tick();
        respond(64'h1040);
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            line_respcyc = (c == 2);
            line_data    = (c == 2) ? {512{1'b1}} : '0;
            if (inst_valid !== 1'b1 || inst_pc !== 64'h1040 || inst_data !== 32'h5000_1040) begin
                $display("FAIL stall[%0d] got=%0b/%h/%h exp=1/1040/50001040", c, inst_valid, inst_pc, inst_data); failures++;
            end checks++;
            tick();
        end
        line_respcyc = 1'b0;
        line_data    = '0;
        if (inst_pc !== 64'h1040 || inst_data !== 32'h5000_1040) begin $display("FAIL stall_end got=%h/%h exp=1040/50001040", inst_pc, inst_data); failures++; end checks++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        if (inst_pc !== 64'h1044 || inst_data !== 32'h5000_1044) begin $display("FAIL stall_hs got=%h/%h exp=1044/50001044", inst_pc, inst_data); failures++; end checks++;
    endtask

    task automatic test_redirect_serve();
        redirect = 1'b1; redirect_pc = 64'h1003;
        tick();
        redirect = 1'b0;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h1000 || inst_valid !== 1'b0) begin
            $display("FAIL redir_far got=%0b/%h/%0b exp=1/1000/0", line_reqcyc, line_addr, inst_valid); failures++;
        end checks++;
        tick();
        respond(64'h1000);
        if (inst_pc !== 64'h1000 || inst_data !== 32'h5000_1000) begin $display("FAIL redir_far_word got=%h/%h exp=1000/50001000", inst_pc, inst_data); failures++; end checks++;
        redirect = 1'b1; redirect_pc = 64'h1024;
        tick();
        redirect = 1'b0;
`ifdef FETCH_SAME_LINE_HIT_EN
        if (line_reqcyc !== 1'b0 || inst_valid !== 1'b1) begin $display("FAIL hit_noreq got=%0b/%0b exp=0/1", line_reqcyc, inst_valid); failures++; end checks++;
`else
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h1000 || inst_valid !== 1'b0) begin
            $display("FAIL same_line_refetch got=%0b/%h/%0b exp=1/1000/0", line_reqcyc, line_addr, inst_valid); failures++;
        end checks++;
        tick();
        respond(64'h1000);
`endif
        if (inst_pc !== 64'h1024 || inst_data !== 32'h5000_1024) begin $display("FAIL same_line_word got=%h/%h exp=1024/50001024", inst_pc, inst_data); failures++; end checks++;
    endtask

    task automatic test_redirect_wait();
        redirect = 1'b1; redirect_pc = 64'h1800;
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 64'h2100;
        tick();
        if (inst_valid !== 1'b0 || line_reqcyc !== 1'b0 || line_addr !== 64'h1800) begin
            $display("FAIL drain_enter got=%0b/%0b/%h exp=0/0/1800", inst_valid, line_reqcyc, line_addr); failures++;
        end checks++;
        redirect_pc = 64'h2008;
        tick();
        redirect = 1'b0;
        if (line_reqcyc !== 1'b0 || line_addr !== 64'h1800) begin $display("FAIL drain_redir got=%0b/%h exp=0/1800", line_reqcyc, line_addr); failures++; end checks++;
        respond(64'h1800);
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h2000 || inst_valid !== 1'b0) begin
            $display("FAIL drain_exit got=%0b/%h/%0b exp=1/2000/0", line_reqcyc, line_addr, inst_valid); failures++;
        end checks++;
        tick();
        respond(64'h2000);
        if (inst_pc !== 64'h2008 || inst_data !== 32'h5000_2008) begin $display("FAIL drain_word got=%h/%h exp=2008/50002008", inst_pc, inst_data); failures++; end checks++;
        redirect = 1'b1; redirect_pc = 64'h3000;
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 64'h2404;
        respond(64'h3000);
        redirect = 1'b0;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h2400) begin $display("FAIL wait_resp_redir got=%0b/%h exp=1/2400", line_reqcyc, line_addr); failures++; end checks++;
        tick();
        respond(64'h2400);
        if (inst_pc !== 64'h2404 || inst_data !== 32'h5000_2404) begin $display("FAIL wait_resp_word got=%h/%h exp=2404/50002404", inst_pc, inst_data); failures++; end checks++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin $display("FAIL wrap_req got=%0b/%h exp=1/ffffffffffffffc0", line_reqcyc, line_addr); failures++; end checks++;
        tick();
        respond(64'hFFFF_FFFF_FFFF_FFC0);
        if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst_data !== 32'h4FFF_FFFC) begin $display("FAIL wrap_word got=%h/%h exp=fffffffffffffffc/4ffffffc", inst_pc, inst_data); failures++; end checks++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h0) begin $display("FAIL wrap_next got=%0b/%h exp=1/0", line_reqcyc, line_addr); failures++; end checks++;
        tick();
        respond(64'h0);
        if (inst_pc !== 64'h0 || inst_data !== 32'h5000_0000 || inst_valid !== 1'b1) begin $display("FAIL wrap_zero got=%0b/%h/%h exp=1/0/50000000", inst_valid, inst_pc, inst_data); failures++; end checks++;
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; redirect_pc = 64'h5000;
        tick();
        redirect = 1'b0;
        tick();
        if (line_addr !== 64'h5000 || line_reqcyc !== 1'b0) begin $display("FAIL mid_wait got=%0b/%h exp=0/5000", line_reqcyc, line_addr); failures++; end checks++;
        reset = 1'b1;
        #1;
        if (line_reqcyc !== 1'b0 || line_addr !== 64'h0 || inst_valid !== 1'b0) begin $display("FAIL mid_rst got=%0b/%h/%0b exp=0/0/0", line_reqcyc, line_addr, inst_valid); failures++; end checks++;
        tick();
        tick();
        reset = 1'b0;
        #1;
        if (line_reqcyc !== 1'b1 || line_addr !== 64'h1000) begin $display("FAIL mid_release got=%0b/%h exp=1/1000", line_reqcyc, line_addr); failures++; end checks++;
        tick();
        if (line_reqcyc !== 1'b0) begin $display("FAIL mid_one_cycle got=%0b exp=0", line_reqcyc); failures++; end checks++;
        respond(64'h1000);
        if (inst_pc !== 64'h1000 || inst_data !== 32'h5000_1000) begin $display("FAIL mid_word got=%h/%h exp=1000/50001000", inst_pc, inst_data); failures++; end checks++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect_serve();
        test_redirect_wait();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_line_buffer.md
FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001: Parameter START_PC, default 64'h0, is the fetch PC loaded at reset; bits [1:0] SHALL be treated as zero.
REQ-002: clk  input  1  single clock; all state updates on posedge clk.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: line_reqcyc  output  1  one-cycle line-read request to the upstream 64-byte line reader.
REQ-005: line_addr  output  64  line address; bits [5:0] always zero.
REQ-006: line_respcyc  input  1  one-cycle strobe: line_data valid this cycle.
REQ-007: line_data  input  [0:511]  line; the word at byte offset 4*i is line_data[32*i +: 32].
REQ-008: inst_valid  output  1  inst_data/inst_pc valid.
REQ-009: inst_ready  input  1  consumer accepts the word when inst_valid && inst_ready.
REQ-010: inst_data  output  32  instruction word at inst_pc.
REQ-011: inst_pc  output  64  byte address of inst_data.
REQ-012: redirect  input  1  one-cycle fetch redirect.
REQ-013: redirect_pc  input  64  new fetch PC; bits [1:0] ignored.

Function
REQ-014: The block SHALL hold one registered 512-bit line buffer, its 64-bit line tag, a 64-bit pc register, and a state register with states REQ, WAIT, SERVE, DRAIN.
REQ-015: REQ: line_reqcyc=1 for exactly this one cycle, line_addr={pc[63:6],6'b0}; next state WAIT.
REQ-016: line_addr SHALL stay constant from the REQ cycle through the cycle line_respcyc is seen in WAIT or DRAIN.
REQ-017: WAIT: on line_respcyc, the buffer SHALL load line_data and the tag SHALL load line_addr; next state SERVE.
REQ-018: SERVE: inst_valid=1, inst_pc=pc, inst_data=buffer word pc[5:2]; latency from the line_respcyc cycle to first inst_valid is exactly 1 cycle.
REQ-019: SERVE: on handshake, pc SHALL advance by 4 modulo 2^64; if pc[5:2] was 15, next state REQ, else stay in SERVE.
REQ-020: inst_valid, inst_data and inst_pc SHALL stay stable while inst_valid && !inst_ready.
REQ-021: redirect SHALL override the handshake in the same cycle: pc<={redirect_pc[63:2],2'b0}, no word consumed.
REQ-022: redirect in SERVE SHALL go to REQ, except as given in REQ-031.
REQ-023: redirect in REQ SHALL go to DRAIN; in WAIT with no line_respcyc, to DRAIN; in WAIT with line_respcyc the same cycle, the line SHALL be discarded and the next state SHALL be REQ.
REQ-024: DRAIN: inst_valid=0; wait for line_respcyc, discard it (buffer/tag unchanged), next state REQ; a further redirect in DRAIN SHALL update pc only.
REQ-025: line_respcyc in REQ or SERVE SHALL be ignored.
REQ-026: inst_valid SHALL be 0 in REQ, WAIT and DRAIN; inst_data/inst_pc SHALL be 0 when inst_valid=0.
REQ-027: At most one line request SHALL be outstanding at any time.

Reset
REQ-028: While reset is high: state=REQ, pc=START_PC, tag invalid, buffer=0, and all outputs 0, including line_reqcyc.
REQ-029: The first line_reqcyc SHALL occur in the first clock edge cycle after reset deasserts, with line_addr={START_PC[63:6],6'b0}.
REQ-030: Reset mid-request SHALL abandon the transaction; the upstream reader is reset by the same signal.

Configuration
REQ-031: With FETCH_SAME_LINE_HIT_EN defined, a redirect in SERVE whose redirect_pc[63:6] equals a valid tag SHALL stay in SERVE with no refetch; inst_valid=1 the next cycle with the new word. Without the macro, every redirect SHALL refetch.

Verification
REQ-032: START_PC=0x1000, reset release -> one-cycle line_reqcyc, line_addr=0x1000; line_respcyc 3 cycles later -> inst_valid next cycle, inst_pc=0x1000, inst_data=line_data[0:31].
REQ-033: inst_ready held 1 over 16 words from 0x1000 -> inst_pc 0x1000..0x103C consecutive, then line_reqcyc with line_addr=0x1040.
REQ-034: inst_ready=0 for 5 cycles in SERVE -> inst_valid/inst_pc/inst_data unchanged; pc advances only on handshake.
REQ-035: redirect to 0x2008 while in WAIT -> DRAIN, stale line_respcyc discarded, then line_reqcyc at 0x2000, first word inst_pc=0x2008.
REQ-036: In SERVE on line 0x1000, redirect to 0x1024 -> with FETCH_SAME_LINE_HIT_EN no line_reqcyc, next inst_pc=0x1024; without the macro line_reqcyc at 0x1000.
REQ-037: pc=0xFFFF_FFFF_FFFF_FFFC handshake -> next line_addr=0x0; reset asserted during WAIT -> outputs 0 immediately, new request from START_PC after release.
